// File: rtl/board_input_conditioner_if.sv
// Pin-side bundle for board_input_conditioner: raw pins in, conditioned levels and strobes out.
// The change_irq/change_irq_clear pair exists only when BOARD_INPUT_CHANGE_IRQ_EN is defined.
interface board_input_conditioner_if #(
    parameter int NUM_INPUTS = 3
);
    logic [NUM_INPUTS-1:0] raw_input;
    logic [NUM_INPUTS-1:0] clean_output;
    logic [NUM_INPUTS-1:0] rise_pulse;
    logic [NUM_INPUTS-1:0] fall_pulse;
    logic                  soc_reset;
    logic                  clock_enable;
`ifdef BOARD_INPUT_CHANGE_IRQ_EN
    logic                  change_irq;
    logic                  change_irq_clear;

    modport master (
        output raw_input, change_irq_clear,
        input  clean_output, rise_pulse, fall_pulse, soc_reset, clock_enable, change_irq
    );
    modport slave (
        input  raw_input, change_irq_clear,
        output clean_output, rise_pulse, fall_pulse, soc_reset, clock_enable, change_irq
    );
`else
    modport master (
        output raw_input,
        input  clean_output, rise_pulse, fall_pulse, soc_reset, clock_enable
    );
    modport slave (
        input  raw_input,
        output clean_output, rise_pulse, fall_pulse, soc_reset, clock_enable
    );
`endif
endinterface

// File: rtl/board_input_conditioner.sv
// Synchronise/debounce board pins, emit edge strobes, stretch the SoC reset and divide a clock enable.
// Optional sticky change interrupt is built when BOARD_INPUT_CHANGE_IRQ_EN is defined.
module board_input_conditioner #(
    parameter int NUM_INPUTS        = 3,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int RESET_CHANNEL     = 0,
    parameter int RESET_HOLD_CYCLES = 8,
    parameter int CLOCK_DIVIDER     = 2
) (
    input logic clock,
    input logic reset,
    board_input_conditioner_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int CW = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLOCK_DIVIDER - 1);

    logic [NUM_INPUTS-1:0] sync_pipe [SYNC_STAGES];
    logic [NUM_INPUTS-1:0] sync;
    logic [DW-1:0]         db_cnt [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] clean;
    logic [NUM_INPUTS-1:0] rise;
    logic [NUM_INPUTS-1:0] fall;
    logic [HW-1:0]         hold_cnt;
    logic                  soc_reset;
    logic [CW-1:0]         div_cnt;
    logic                  clock_enable;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_pipe[s] <= '0;
        end else begin
            sync_pipe[0] <= bus.raw_input;
            for (int s = 1; s < SYNC_STAGES; s++) sync_pipe[s] <= sync_pipe[s-1];
        end
    end

    assign sync = sync_pipe[SYNC_STAGES-1];

    // A mismatch must persist DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            clean <= '0;
            rise  <= '0;
            fall  <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                rise[i] <= 1'b0;
                fall[i] <= 1'b0;
                if (sync[i] == clean[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    clean[i]  <= sync[i];
                    rise[i]   <= sync[i];
                    fall[i]   <= ~sync[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clean[RESET_CHANNEL]) begin
            soc_reset <= 1'b1;
            hold_cnt  <= '0;
        end else if (soc_reset) begin
            if (hold_cnt == HOLD_LAST) begin
                soc_reset <= 1'b0;
                hold_cnt  <= '0;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // Free-running divider; deliberately unaffected by soc_reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt      <= '0;
            clock_enable <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt      <= '0;
            clock_enable <= 1'b1;
        end else begin
            div_cnt      <= div_cnt + 1'b1;
            clock_enable <= 1'b0;
        end
    end

    assign bus.clean_output = clean;
    assign bus.rise_pulse   = rise;
    assign bus.fall_pulse   = fall;
    assign bus.soc_reset    = soc_reset;
    assign bus.clock_enable = clock_enable;

`ifdef BOARD_INPUT_CHANGE_IRQ_EN
    logic change_irq;

    always_ff @(posedge clock) begin
        if (reset) begin
            change_irq <= 1'b0;
        end else if ((|rise) || (|fall)) begin
            change_irq <= 1'b1;
        end else if (bus.change_irq_clear) begin
            change_irq <= 1'b0;
        end
    end

    assign bus.change_irq = change_irq;
`endif
endmodule
